sha1_round_core: RTL

SHA1_ROUND_CORE -- requirements
Module: sha1_round_core

---
 rtl/sha1_pkg.sv | 42 ++++
 rtl/sha1_round_core_if.sv | 25 ++
 rtl/sha1_round.sv | 44 ++++
 rtl/sha1_round_core.sv | 97 +++++++++
 4 files changed

// File: rtl/sha1_pkg.sv
// Shared SHA-1 constants, FSM state encoding and working-variable bundle
// for the round core and its round datapath.
package sha1_pkg;

    localparam int         ROUNDS = 80;
    localparam logic [6:0] LAST_T = 7'(ROUNDS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ROUND,
        S_UPDATE,
        S_DONE
    } state_t;

    // Packed with a at the MSB so an H bundle maps straight onto the digest port
    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        logic [31:0] d;
        logic [31:0] e;
    } work_t;

    localparam work_t IV = '{
        a: 32'h67452301,
        b: 32'hEFCDAB89,
        c: 32'h98BADCFE,
        d: 32'h10325476,
        e: 32'hC3D2E1F0
    };

    localparam logic [31:0] K0 = 32'h5A827999;
    localparam logic [31:0] K1 = 32'h6ED9EBA1;
    localparam logic [31:0] K2 = 32'h8F1BBCDC;
    localparam logic [31:0] K3 = 32'hCA62C1D6;

    function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

endpackage

// File: rtl/sha1_round_core_if.sv
// Handshake and schedule-engine strobes between an upstream controller and
// the SHA-1 round core.
interface sha1_round_core_if;

    logic         start;
    logic         first;
    logic [31:0]  wout;
    logic         ready;
    logic         feed;
    logic         next;
    logic         stage;
    logic         done;
    logic [159:0] digest;

    modport master (
        output start, first, wout,
        input  ready, feed, next, stage, done, digest
    );

    modport slave (
        input  start, first, wout,
        output ready, feed, next, stage, done, digest
    );

endinterface

// File: rtl/sha1_round.sv
// One SHA-1 round: f/K selection by round index, the temp adder and the
// a..e rotation. Purely combinational; the core owns the registers.
module sha1_round
    import sha1_pkg::*;
(
    input  work_t       cur,
    input  logic [6:0]  t,
    input  logic [31:0] w,
    output work_t       nxt
);

    logic [31:0] f;
    logic [31:0] k;
    logic [31:0] temp;

    always_comb begin
        f = cur.b ^ cur.c ^ cur.d;
        k = K1;
        if (t < 7'd20) begin
            f = (cur.b & cur.c) | (~cur.b & cur.d);
            k = K0;
        end else if (t < 7'd40) begin
            f = cur.b ^ cur.c ^ cur.d;
            k = K1;
        end else if (t < 7'd60) begin
            f = (cur.b & cur.c) | (cur.b & cur.d) | (cur.c & cur.d);
            k = K2;
        end else begin
            f = cur.b ^ cur.c ^ cur.d;
            k = K3;
        end
    end

    assign temp = rotl(cur.a, 5) + f + cur.e + k + w;

    always_comb begin
        nxt.a = temp;
        nxt.b = cur.a;
        nxt.c = rotl(cur.b, 30);
        nxt.d = cur.c;
        nxt.e = cur.d;
    end

endmodule

// File: rtl/sha1_round_core.sv
// SHA-1 compression controller: sequences 80 rounds against an external
// message-schedule engine and accumulates the chained digest.
module sha1_round_core
    import sha1_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    sha1_round_core_if.slave bus
);

    state_t     state_q, state_d;
    logic [6:0] t_q;
    work_t      work_q;
    work_t      work_rnd;
    work_t      h_q;

    sha1_round u_round (
        .cur (work_q),
        .t   (t_q),
        .w   (bus.wout),
        .nxt (work_rnd)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Strobes decode from state only, so reset clears them without a clock
    always_comb begin
        state_d   = state_q;
        bus.ready = 1'b0;
        bus.feed  = 1'b0;
        bus.next  = 1'b0;
        bus.stage = 1'b0;
        bus.done  = 1'b0;
        case (state_q)
            S_IDLE: begin
                bus.ready = 1'b1;
                if (bus.start) state_d = S_LOAD;
            end
            S_LOAD: begin
                bus.feed = 1'b1;
                state_d  = S_ROUND;
            end
            S_ROUND: begin
                bus.next  = (t_q != LAST_T);
                bus.stage = (t_q >= 7'd15) && (t_q != LAST_T);
                if (t_q == LAST_T) state_d = S_UPDATE;
            end
            S_UPDATE: state_d = S_DONE;
            S_DONE: begin
                bus.done = 1'b1;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            t_q    <= '0;
            work_q <= '0;
            h_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    t_q <= '0;
                    if (bus.start) begin
                        if (bus.first) begin
                            h_q    <= IV;
                            work_q <= IV;
                        end else begin
                            work_q <= h_q;
                        end
                    end
                end
                S_LOAD: t_q <= '0;
                S_ROUND: begin
                    work_q <= work_rnd;
                    t_q    <= t_q + 7'd1;
                end
                S_UPDATE: begin
                    h_q.a <= h_q.a + work_q.a;
                    h_q.b <= h_q.b + work_q.b;
                    h_q.c <= h_q.c + work_q.c;
                    h_q.d <= h_q.d + work_q.d;
                    h_q.e <= h_q.e + work_q.e;
                end
                default: ;
            endcase
        end
    end

    assign bus.digest = h_q;

endmodule
